// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard fields from the datapath and the
// pipeline-register strobes returned by the hazard controller.
// slave  : controller side (fields in, strobes out)
// master : datapath side (fields out, strobes in)
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] ex_rd;
  logic       ex_mem_reg_write;
  logic       ex_long_write;
  logic       ex_branch_taken;
  logic       wb_mem_req;
  logic       mem_ready;
  logic       pc_we;
  logic       if_id_we;
  logic       if_id_clr;
  logic       id_ex_we;
  logic       id_ex_clr;
  logic       ex_wb_we;
  logic       ex_wb_clr;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rd,
    output ex_mem_reg_write, ex_long_write,
    output ex_branch_taken, wb_mem_req, mem_ready,
    input  pc_we, if_id_we, if_id_clr,
    input  id_ex_we, id_ex_clr, ex_wb_we, ex_wb_clr
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rd,
    input  ex_mem_reg_write, ex_long_write,
    input  ex_branch_taken, wb_mem_req, mem_ready,
    output pc_we, if_id_we, if_id_clr,
    output id_ex_we, id_ex_clr, ex_wb_we, ex_wb_clr
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline-register strobe generator resolving
// load-use, taken-branch, long-writeback and memory-wait hazards.
// Ports: clk, reset (sync, active-high), hz (slave: hazard fields
// in, pc/IF_ID/ID_EX/EX_WBTL we+clr out), mem_err (sticky timeout),
// stall_cycles / flush_count (perf counters).
// Macro PIPE_HAZARD_CTRL_PERF_EN enables the perf counters;
// otherwise both counter outputs are tied to zero.
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  pipe_hazard_ctrl_if.slave hz,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    LOAD_STALL,
    LONG_WB
  } state_t;

  localparam logic [2:0] LS_LAST  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [9:0] TO_MAX   = 10'(MEM_TIMEOUT);
  localparam bit         LS_MULTI = (LOAD_STALL_CYCLES > 1);

  state_t     state_q, state_d;
  logic [2:0] ls_cnt_q, ls_cnt_d;
  logic [9:0] to_cnt_q, to_cnt_d;
  logic       mem_err_d;

  logic ld_use, mem_evt;
  logic pc_we, if_id_we, if_id_clr;
  logic id_ex_we, id_ex_clr, ex_wb_we, ex_wb_clr;

  assign ld_use = hz.ex_mem_reg_write
                & (hz.ex_rd != 5'd0)
                & ((hz.ex_rd == hz.id_rs)
                 | (hz.id_uses_rt & (hz.ex_rd == hz.id_rt)));

  assign mem_evt = hz.wb_mem_req & ~hz.mem_ready;

  always_comb begin
    state_d   = state_q;
    ls_cnt_d  = ls_cnt_q;
    to_cnt_d  = to_cnt_q;
    mem_err_d = mem_err;
    pc_we     = 1'b1;
    if_id_we  = 1'b1;
    id_ex_we  = 1'b1;
    ex_wb_we  = 1'b1;
    if_id_clr = 1'b0;
    id_ex_clr = 1'b0;
    ex_wb_clr = 1'b0;

    if (reset) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_wb_we  = 1'b0;
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
      ex_wb_clr = 1'b1;
    end else if (state_q == MEM_WAIT) begin
      if (hz.mem_ready) begin
        state_d = RUN;
      end else begin
        pc_we    = 1'b0;
        if_id_we = 1'b0;
        id_ex_we = 1'b0;
        ex_wb_we = 1'b0;
        if (to_cnt_q >= TO_MAX) begin
          // abort: flush everything in flight
          if_id_clr = 1'b1;
          id_ex_clr = 1'b1;
          ex_wb_clr = 1'b1;
          mem_err_d = 1'b1;
          state_d   = RUN;
        end else begin
          to_cnt_d = to_cnt_q + 10'd1;
        end
      end
    end else if (mem_evt) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      id_ex_we = 1'b0;
      ex_wb_we = 1'b0;
      state_d  = MEM_WAIT;
      to_cnt_d = 10'd1;
    end else if (state_q == LONG_WB) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      id_ex_we = 1'b0;
      ex_wb_we = 1'b0;
      state_d  = RUN;
    end else if (hz.ex_branch_taken) begin
      // squashes a dependent load-use consumer too
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
      state_d   = RUN;
    end else if (state_q == LOAD_STALL || ld_use) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_clr = 1'b1;
      if (state_q == LOAD_STALL) begin
        ls_cnt_d = ls_cnt_q + 3'd1;
        if (ls_cnt_q == LS_LAST) state_d = RUN;
      end else if (LS_MULTI) begin
        state_d  = LOAD_STALL;
        ls_cnt_d = 3'd1;
      end
    end else if (hz.ex_long_write) begin
      state_d = LONG_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      ls_cnt_q <= 3'd0;
      to_cnt_q <= 10'd0;
      mem_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ls_cnt_q <= ls_cnt_d;
      to_cnt_q <= to_cnt_d;
      mem_err  <= mem_err_d;
    end
  end

  assign hz.pc_we     = pc_we;
  assign hz.if_id_we  = if_id_we;
  assign hz.if_id_clr = if_id_clr;
  assign hz.id_ex_we  = id_ex_we;
  assign hz.id_ex_clr = id_ex_clr;
  assign hz.ex_wb_we  = ex_wb_we;
  assign hz.ex_wb_clr = ex_wb_clr;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (!pc_we)    stall_cycles <= stall_cycles + 32'd1;
      if (if_id_clr) flush_count  <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule
